// File: rtl/mac_acc_16.sv
// Burst multiply-accumulate stage: operand, product and accumulate pipeline
// around a radix-4 Booth / Wallace-tree 16x16 signed multiplier.

module mul_tc_16_16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] product
);
   logic [31:0] pp [8];
   logic [16:0] bext;
   logic [31:0] s [6];
   logic [31:0] c [6];

   function automatic logic [31:0] booth_pp(input logic [15:0] m, input logic [2:0] sel);
      logic signed [31:0] me;
      me = 32'(signed'(m));
      case (sel)
         3'b001, 3'b010: booth_pp = me;
         3'b011:         booth_pp = me <<< 1;
         3'b100:         booth_pp = -(me <<< 1);
         3'b101, 3'b110: booth_pp = -me;
         default:        booth_pp = '0;
      endcase
   endfunction

   function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      logic [31:0] maj;
      maj = (x & y) | (x & z) | (y & z);
      return {x ^ y ^ z, maj << 1};
   endfunction

   always_comb begin
      bext = {b, 1'b0};
      for (int i = 0; i < 8; i++) begin
         pp[i] = booth_pp(a, bext[2*i +: 3]) << (2 * i);
      end
   end

   // Wallace reduction 8 -> 6 -> 4 -> 3 -> 2, then one carry-propagate add
   assign {s[0], c[0]} = csa(pp[0], pp[1], pp[2]);
   assign {s[1], c[1]} = csa(pp[3], pp[4], pp[5]);
   assign {s[2], c[2]} = csa(s[0], c[0], s[1]);
   assign {s[3], c[3]} = csa(c[1], pp[6], pp[7]);
   assign {s[4], c[4]} = csa(s[2], c[2], s[3]);
   assign {s[5], c[5]} = csa(s[4], c[4], c[3]);
   assign product = s[5] + c[5];
endmodule

module mac_acc_16 #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

   state_t                   state;
   logic [CNT_W-1:0]         rem;
   logic signed [ACC_W-1:0]  acc;
   logic                     ovf;
   logic signed [15:0]       a_p0, b_p0;
   logic                     vld_p0;
   logic signed [31:0]       prod_p1;
   logic                     vld_p1;
   logic [31:0]              prod;
   logic                     accept;
   logic signed [ACC_W-1:0]  prod_ext, acc_sum;
   logic                     sum_ovf;

   function automatic logic add_ovf(input logic signed [ACC_W-1:0] x,
                                    input logic signed [ACC_W-1:0] y,
                                    input logic signed [ACC_W-1:0] sum);
      return (x[ACC_W-1] == y[ACC_W-1]) && (sum[ACC_W-1] != x[ACC_W-1]);
   endfunction

   assign in_ready = (state == ACC) && (rem != '0);
   assign accept   = in_valid & in_ready;

   mul_tc_16_16 u_mul (
      .a       (a_p0),
      .b       (b_p0),
      .product (prod)
   );

   assign prod_ext = ACC_W'(prod_p1);
   assign acc_sum  = acc + prod_ext;
   assign sum_ovf  = add_ovf(acc, prod_ext, acc_sum);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_p0    <= '0;
         b_p0    <= '0;
         vld_p0  <= 1'b0;
         prod_p1 <= '0;
         vld_p1  <= 1'b0;
      end else begin
         // operand stage
         vld_p0 <= accept;
         if (accept) begin
            a_p0 <= signed'(in_a);
            b_p0 <= signed'(in_b);
         end
         // product stage
         vld_p1 <= vld_p0;
         if (vld_p0) prod_p1 <= signed'(prod);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rem       <= '0;
         acc       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_ovf   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc  <= '0;
                  ovf  <= 1'b0;
                  busy <= 1'b1;
                  if (len != '0) begin
                     state <= ACC;
                     rem   <= len;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     out_acc   <= '0;
                     out_ovf   <= 1'b0;
                  end
               end
            end
            ACC: begin
               if (accept) begin
                  rem <= rem - 1'b1;
                  if (rem == CNT_W'(1)) state <= DRAIN;
               end
               if (vld_p1) begin
                  acc <= acc_sum;
                  ovf <= ovf | sum_ovf;
               end
            end
            DRAIN: begin
               if (vld_p1) begin
                  acc <= acc_sum;
                  ovf <= ovf | sum_ovf;
                  // last product lands this edge when nothing is behind it
                  if (!vld_p0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     out_acc   <= acc_sum;
                     out_ovf   <= ovf | sum_ovf;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_acc_16.sv
// Scoreboard bench for mac_acc_16: a 40-bit and a 32-bit instance share stimulus.

module tb_mac_acc_16;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [15:0] in_a, in_b;
   logic        out_ready;

   logic        in_ready_40, out_valid_40, out_ovf_40, busy_40;
   logic [39:0] out_acc_40;
   logic        in_ready_32, out_valid_32, out_ovf_32, busy_32;
   logic [31:0] out_acc_32;

   typedef struct packed {
      logic [63:0] acc40;
      logic        ovf40;
      logic [63:0] acc32;
      logic        ovf32;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   ready_cnt = 0;
   int   rem_m = 0;
   logic signed [39:0] m40;
   logic signed [31:0] m32;
   logic mo40, mo32;

   mac_acc_16 #(.ACC_W(40), .CNT_W(8)) dut40 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready_40), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid_40), .out_ready(out_ready), .out_acc(out_acc_40),
      .out_ovf(out_ovf_40), .busy(busy_40)
   );

   mac_acc_16 #(.ACC_W(32), .CNT_W(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready_32), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid_32), .out_ready(out_ready), .out_acc(out_acc_32),
      .out_ovf(out_ovf_32), .busy(busy_32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp();
      sb.push_back({{24'd0, m40}, mo40, {32'd0, m32}, mo32});
   endtask

   task automatic model_beat(input logic signed [15:0] a, input logic signed [15:0] b);
      int p;
      logic signed [39:0] p40, s40;
      logic signed [31:0] p32, s32;
      p   = int'(a) * int'(b);
      p40 = {{8{p[31]}}, p};
      p32 = p;
      s40 = m40 + p40;
      s32 = m32 + p32;
      if (m40[39] == p40[39] && s40[39] != m40[39]) mo40 = 1'b1;
      if (m32[31] == p32[31] && s32[31] != m32[31]) mo32 = 1'b1;
      m40 = s40;
      m32 = s32;
   endtask

   task automatic start_burst(input logic [7:0] n);
      m40 = '0; m32 = '0; mo40 = 1'b0; mo32 = 1'b0;
      rem_m = int'(n);
      if (n == 8'd0) push_exp();
      start = 1'b1;
      len   = n;
      tick();
      start = 1'b0;
   endtask

   task automatic send_beat(input logic signed [15:0] a, input logic signed [15:0] b,
                            input int gap, input bit keep);
      int n;
      in_a = a; in_b = b; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready_40 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         check("beat_timeout", {63'd0, in_ready_40}, 64'd1);
         in_valid = 1'b0;
         return;
      end
      tick();
      model_beat(a, b);
      rem_m--;
      if (rem_m == 0) push_exp();
      if (!keep) in_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid_40 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("valid_timeout", {63'd0, out_valid_40}, 64'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("done_timeout", 64'(sb.size()), 64'd0);
      tick();
   endtask

   // scoreboard monitor: every cycle a result is offered it must match the queue head
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_ready_40) ready_cnt++;
         if (out_valid_40 || out_valid_32) begin
            if (sb.size() == 0) begin
               check("spurious_valid", {63'd0, out_valid_40 | out_valid_32}, 64'd0);
            end else begin
               check("acc40",   {24'd0, out_acc_40}, sb[0].acc40);
               check("ovf40",   {63'd0, out_ovf_40}, {63'd0, sb[0].ovf40});
               check("acc32",   {32'd0, out_acc_32}, sb[0].acc32);
               check("ovf32",   {63'd0, out_ovf_32}, {63'd0, sb[0].ovf32});
               check("valid40", {63'd0, out_valid_40}, 64'd1);
               check("valid32", {63'd0, out_valid_32}, 64'd1);
               if (out_ready && out_valid_40) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
      in_a = '0; in_b = '0; out_ready = 1'b1;
      m40 = '0; m32 = '0; mo40 = 1'b0; mo32 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  {63'd0, in_ready_40}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid_40}, 64'd0);
      check("rst_out_acc",   {24'd0, out_acc_40}, 64'd0);
      check("rst_out_ovf",   {63'd0, out_ovf_40}, 64'd0);
      check("rst_busy",      {63'd0, busy_40}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // single pair with latency check
      start_burst(8'd1);
      check("busy_acc", {63'd0, busy_40}, 64'd1);
      send_beat(16'sd3, -16'sd4, 0, 1'b0);
      @(negedge clk);
      check("lat_k", {63'd0, out_valid_40}, 64'd0);
      @(negedge clk);
      check("lat_k1", {63'd0, out_valid_40}, 64'd0);
      @(negedge clk);
      check("lat_k2", {63'd0, out_valid_40}, 64'd1);
      check("single_acc", {24'd0, out_acc_40}, 64'h00FFFFFFFFF4);
      check("single_ovf", {63'd0, out_ovf_40}, 64'd0);
      wait_done();

      // back-to-back burst, in_valid held high
      ready_cnt = 0;
      start_burst(8'd4);
      for (int i = 0; i < 4; i++) send_beat(16'sh8000, 16'sh8000, 0, 1'b1);
      in_valid = 1'b0;
      wait_valid();
      check("b2b_acc", {24'd0, out_acc_40}, 64'h0100000000);
      check("b2b_ovf", {63'd0, out_ovf_40}, 64'd0);
      wait_done();
      check("b2b_ready_cycles", 64'(ready_cnt), 64'd4);

      // bubbles, ignored starts, and output backpressure
      out_ready = 1'b0;
      start_burst(8'd3);
      send_beat(16'sd100, 16'sd200, 0, 1'b0);
      start = 1'b1; len = 8'd7;
      tick();
      start = 1'b0;
      tick();
      send_beat(-16'sd7, 16'sd9, 2, 1'b0);
      send_beat(16'sh7FFF, 16'sd2, 0, 1'b0);
      wait_valid();
      check("bub_acc", {24'd0, out_acc_40}, 64'd85471);
      check("bub_busy", {63'd0, busy_40}, 64'd1);
      repeat (5) begin
         tick();
         start = 1'b1; len = 8'd2;
      end
      out_ready = 1'b1; start = 1'b1; len = 8'd1;
      tick();
      start = 1'b0;
      @(negedge clk);
      check("start_at_handshake_busy", {63'd0, busy_40}, 64'd0);
      check("start_at_handshake_valid", {63'd0, out_valid_40}, 64'd0);
      wait_done();

      // overflow at 32 bits, then a clean burst clears the flag
      start_burst(8'd3);
      for (int i = 0; i < 3; i++) send_beat(16'sh8000, 16'sh8000, 0, 1'b1);
      in_valid = 1'b0;
      wait_valid();
      check("ovf32_acc", {32'd0, out_acc_32}, 64'hC0000000);
      check("ovf32_flag", {63'd0, out_ovf_32}, 64'd1);
      wait_done();
      start_burst(8'd1);
      send_beat(16'sd1, 16'sd1, 0, 1'b0);
      wait_valid();
      check("after_ovf_acc", {32'd0, out_acc_32}, 64'd1);
      check("after_ovf_flag", {63'd0, out_ovf_32}, 64'd0);
      wait_done();

      // zero length; in_valid outside ACC is ignored
      ready_cnt = 0;
      in_valid = 1'b1;
      start_burst(8'd0);
      @(negedge clk);
      check("zero_valid", {63'd0, out_valid_40}, 64'd1);
      check("zero_acc", {24'd0, out_acc_40}, 64'd0);
      wait_done();
      in_valid = 1'b0;
      check("zero_no_ready", 64'(ready_cnt), 64'd0);

      // reset mid-burst aborts; the next burst is unaffected
      start_burst(8'd4);
      send_beat(16'sd1000, 16'sd1000, 0, 1'b1);
      send_beat(16'sd1000, 16'sd1000, 0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready",  {63'd0, in_ready_40 | in_ready_32}, 64'd0);
      check("mid_rst_out_valid", {63'd0, out_valid_40 | out_valid_32}, 64'd0);
      check("mid_rst_acc40",     {24'd0, out_acc_40}, 64'd0);
      check("mid_rst_acc32",     {32'd0, out_acc_32}, 64'd0);
      check("mid_rst_ovf",       {63'd0, out_ovf_40 | out_ovf_32}, 64'd0);
      check("mid_rst_busy",      {63'd0, busy_40 | busy_32}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      start_burst(8'd1);
      send_beat(16'sd5, 16'sd5, 0, 1'b0);
      wait_valid();
      check("post_rst_acc", {24'd0, out_acc_40}, 64'd25);
      wait_done();
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
